// File: rtl/cdcm_rx_word_aligner_pkg.sv
// Shared types and helpers for the CDCM receive word aligner.
// Holds the per-lane search state encoding and the default training word.
package cdcm_rx_word_aligner_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SETTLE,
    S_LOCKED,
    S_FAIL
  } align_state_e;

  localparam logic [7:0] kDefaultTrainPattern = 8'hF0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/cdcm_rx_word_aligner_lane.sv
// One receive lane: polarity, two-word pipeline, slip mux,
// slip counter and the training-pattern search FSM.
module cdcm_rx_lane_aligner
  import cdcm_rx_word_aligner_pkg::*;
#(
  parameter int kDevW = 8,
  parameter int kSelCount = clog2(kDevW),
  parameter logic [kDevW-1:0] kTrainPattern =
    kDevW'(kDefaultTrainPattern),
  parameter int kMatchCount = 16,
  parameter int kSettleCycles = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [kDevW-1:0]     din,
  input  logic                 pol_inv,
  input  logic                 bitslip,
  input  logic                 align_start,
  output logic [kDevW-1:0]     dout,
  output logic [kSelCount-1:0] slip_pos,
  output logic                 align_done,
  output logic                 align_error
);

  localparam int kMcW =
    (kMatchCount > 1) ? clog2(kMatchCount) : 1;
  localparam int kStW =
    (kSettleCycles > 1) ? clog2(kSettleCycles) : 1;
  localparam int kSettleLastI =
    (kSettleCycles > 0) ? kSettleCycles - 1 : 0;

  localparam logic [kMcW-1:0] kMatchLast =
    kMcW'(kMatchCount - 1);
  localparam logic [kStW-1:0] kSettleLast =
    kStW'(kSettleLastI);
  localparam logic [kSelCount-1:0] kPosLast =
    kSelCount'(kDevW - 1);
  localparam logic [kSelCount:0] kWidth =
    (kSelCount + 1)'(kDevW);

  logic [kDevW-1:0]     a_d, a_q;
  logic [kDevW-1:0]     b_d, b_q;
  logic [kDevW-1:0]     dout_d, dout_q;
  logic [kDevW-1:0]     word;
  logic [2*kDevW-1:0]   cat;
  logic [kSelCount:0]   base;
  logic [kSelCount-1:0] s_d, s_q, s_inc;
  logic [kSelCount-1:0] tried_d, tried_q;
  logic [kMcW-1:0]      match_d, match_q;
  logic [kStW-1:0]      settle_d, settle_q;
  logic                 done_d, done_q;
  logic                 err_d, err_q;
  logic                 hit;
  align_state_e         state_d, state_q;

  // Window of the {A,B} bit stream selected by the slip position.
  always_comb begin
    a_d    = pol_inv ? ~din : din;
    b_d    = a_q;
    cat    = {a_q, b_q};
    base   = kWidth - {1'b0, s_q};
    word   = cat[base +: kDevW];
    dout_d = word;
    hit    = (word == kTrainPattern);
    s_inc  = (s_q == kPosLast) ? '0 : s_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    tried_d  = tried_q;
    match_d  = match_q;
    settle_d = settle_q;
    done_d   = done_q;
    err_d    = err_q;
    if (align_start) begin
      state_d  = S_CHECK;
      tried_d  = '0;
      match_d  = '0;
      settle_d = '0;
      done_d   = 1'b0;
      err_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bitslip) s_d = s_inc;
        end
        S_CHECK: begin
          if (hit) begin
            if (match_q == kMatchLast) begin
              state_d = S_LOCKED;
              done_d  = 1'b1;
              match_d = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            // The last miss also advances, so a failed
            // lane wraps back to where its search began.
            match_d = '0;
            s_d     = s_inc;
            if (tried_q == kPosLast) begin
              state_d = S_FAIL;
              err_d   = 1'b1;
            end else begin
              tried_d  = tried_q + 1'b1;
              settle_d = '0;
              state_d  = (kSettleCycles == 0) ? S_CHECK
                                              : S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (settle_q == kSettleLast) begin
            state_d = S_CHECK;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        S_LOCKED: begin
          if (bitslip) begin
            s_d     = s_inc;
            done_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        S_FAIL: begin
          if (bitslip) s_d = s_inc;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      dout_q   <= '0;
      s_q      <= '0;
      tried_q  <= '0;
      match_q  <= '0;
      settle_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      state_q  <= S_IDLE;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      dout_q   <= dout_d;
      s_q      <= s_d;
      tried_q  <= tried_d;
      match_q  <= match_d;
      settle_q <= settle_d;
      done_q   <= done_d;
      err_q    <= err_d;
      state_q  <= state_d;
    end
  end

  assign dout        = dout_q;
  assign slip_pos    = s_q;
  assign align_done  = done_q;
  assign align_error = err_q;

endmodule

// File: rtl/cdcm_rx_word_aligner.sv
// Multi-lane CDCM receive word aligner: one independent
// lane aligner per channel plus the all-lanes-locked flag.
module cdcm_rx_word_aligner
  import cdcm_rx_word_aligner_pkg::*;
#(
  parameter int kNumCh = 4,
  parameter int kDevW = 8,
  parameter int kSelCount = clog2(kDevW),
  parameter logic [kDevW-1:0] kTrainPattern =
    kDevW'(kDefaultTrainPattern),
  parameter int kMatchCount = 16,
  parameter int kSettleCycles = 2
) (
  input  logic                        clkDivIn,
  input  logic                        ioReset,
  input  logic [kNumCh*kDevW-1:0]     dInFromSerdes,
  input  logic [kNumCh-1:0]           polarityInv,
  input  logic [kNumCh-1:0]           bitslip,
  input  logic                        alignStart,
  output logic [kNumCh*kDevW-1:0]     dOutToDevice,
  output logic [kNumCh*kSelCount-1:0] slipPos,
  output logic [kNumCh-1:0]           alignDone,
  output logic [kNumCh-1:0]           alignError,
  output logic                        allAligned
);

  for (genvar c = 0; c < kNumCh; c++) begin : g_lane
    cdcm_rx_lane_aligner #(
      .kDevW         (kDevW),
      .kSelCount     (kSelCount),
      .kTrainPattern (kTrainPattern),
      .kMatchCount   (kMatchCount),
      .kSettleCycles (kSettleCycles)
    ) u_lane (
      .clk         (clkDivIn),
      .rst         (ioReset),
      .din         (dInFromSerdes[c*kDevW +: kDevW]),
      .pol_inv     (polarityInv[c]),
      .bitslip     (bitslip[c]),
      .align_start (alignStart),
      .dout        (dOutToDevice[c*kDevW +: kDevW]),
      .slip_pos    (slipPos[c*kSelCount +: kSelCount]),
      .align_done  (alignDone[c]),
      .align_error (alignError[c])
    );
  end

  assign allAligned = &alignDone;

endmodule

// File: tb/tb_cdcm_rx_word_aligner.sv
// Randomised bench for cdcm_rx_word_aligner against a
// rotation-search reference model.
module tb_cdcm_rx_word_aligner;

  localparam int NCH = 4;
  localparam int W = 8;
  localparam int SW = 3;
  localparam int MC = 16;
  localparam int ST = 2;
  localparam logic [7:0] PAT = 8'hF0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH*W-1:0] din = '0;
  logic [NCH-1:0] pol = '0;
  logic [NCH-1:0] slip = '0;
  logic start = 1'b0;
  logic [NCH*W-1:0] dout;
  logic [NCH*SW-1:0] spos;
  logic [NCH-1:0] done;
  logic [NCH-1:0] err;
  logic all_al;

  int checks = 0;
  int failures = 0;
  logic [7:0] lane_din [NCH];
  logic lane_pol [NCH];
  int exp_s [NCH];

  always #5 clk = ~clk;

  cdcm_rx_word_aligner #(
    .kNumCh(NCH), .kDevW(W), .kSelCount(SW),
    .kTrainPattern(PAT), .kMatchCount(MC),
    .kSettleCycles(ST)
  ) dut (
    .clkDivIn(clk), .ioReset(rst),
    .dInFromSerdes(din), .polarityInv(pol),
    .bitslip(slip), .alignStart(start),
    .dOutToDevice(dout), .slipPos(spos),
    .alignDone(done), .alignError(err),
    .allAligned(all_al)
  );

  // Window of the bit stream hi:lo starting s bits into hi.
  function automatic logic [7:0] win(input logic [7:0] hi,
                                     input logic [7:0] lo,
                                     input int s);
    logic [15:0] d;
    d = {hi, lo} >> (W - s);
    return d[7:0];
  endfunction

  function automatic int lane_pos(input int c);
    return int'(spos[c*SW +: SW]);
  endfunction

  function automatic logic [7:0] lane_dout(input int c);
    return dout[c*W +: W];
  endfunction

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      din[c*W +: W] = lane_din[c];
      pol[c] = lane_pol[c];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) exp_s[c] = 0;
  endtask

  task automatic set_lockable(input int c);
    logic [7:0] rot;
    rot = win(PAT, PAT, $urandom_range(0, W - 1));
    lane_pol[c] = 1'($urandom);
    lane_din[c] = lane_pol[c] ? ~rot : rot;
  endtask

  task automatic run_search(input string tag);
    int fd [NCH];
    int steps [NCH];
    bit xd [NCH];
    bit xe [NCH];
    logic [7:0] x;
    drive();
    repeat (3) @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      fd[c] = -1;
      steps[c] = 0;
      xd[c] = 1'b0;
      x = lane_pol[c] ? ~lane_din[c] : lane_din[c];
      for (int k = 0; k < W; k++)
        if (!xd[c] && win(x, x, (exp_s[c] + k) % W) == PAT) begin
          xd[c] = 1'b1;
          steps[c] = k;
        end
      xe[c] = !xd[c];
      exp_s[c] = (exp_s[c] + steps[c]) % W;
    end
    start = 1'b1;
    slip = NCH'($urandom);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 120; n++) begin
      for (int c = 0; c < NCH; c++)
        if (done[c] && fd[c] < 0) fd[c] = n;
      slip = (n <= 4) ? NCH'($urandom) : '0;
      @(negedge clk);
    end
    slip = '0;
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (done[c] !== xd[c]) begin
        failures++;
        $display("FAIL %s_done lane%0d got=%b exp=%b",
                 tag, c, done[c], xd[c]);
      end
      checks++;
      if (err[c] !== xe[c]) begin
        failures++;
        $display("FAIL %s_error lane%0d got=%b exp=%b",
                 tag, c, err[c], xe[c]);
      end
      checks++;
      if (lane_pos(c) !== exp_s[c]) begin
        failures++;
        $display("FAIL %s_slippos lane%0d got=%0d exp=%0d",
                 tag, c, lane_pos(c), exp_s[c]);
      end
      if (xd[c]) begin
        checks++;
        if (lane_dout(c) !== PAT) begin
          failures++;
          $display("FAIL %s_dout lane%0d got=%h exp=%h",
                   tag, c, lane_dout(c), PAT);
        end
        checks++;
        if (fd[c] < MC || fd[c] > steps[c] * (1 + ST) + MC + 4) begin
          failures++;
          $display("FAIL %s_latency lane%0d got=%0d max=%0d",
                   tag, c, fd[c], steps[c] * (1 + ST) + MC + 4);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    slip = '0;
    for (int c = 0; c < NCH; c++) begin
      lane_din[c] = 8'($urandom);
      lane_pol[c] = 1'($urandom);
    end
    drive();
    repeat (3) @(negedge clk);
    checks++;
    if (dout !== '0) begin
      failures++;
      $display("FAIL reset_dout got=%h exp=0", dout);
    end
    checks++;
    if (spos !== '0 || done !== '0 || err !== '0) begin
      failures++;
      $display("FAIL reset_status got=%h/%b/%b exp=0",
               spos, done, err);
    end
    checks++;
    if (all_al !== 1'b0) begin
      failures++;
      $display("FAIL reset_allaligned got=%b exp=0", all_al);
    end
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) exp_s[c] = 0;
  endtask

  task automatic test_manual_slip();
    lane_din[3] = 8'h81;
    lane_pol[3] = 1'b0;
    drive();
    for (int i = 0; i < 10; i++) begin
      slip[3] = 1'b1;
      @(negedge clk);
      slip[3] = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    exp_s[3] = (exp_s[3] + 10) % W;
    @(negedge clk);
    checks++;
    if (lane_pos(3) !== 2) begin
      failures++;
      $display("FAIL manual_slippos got=%0d exp=2", lane_pos(3));
    end
    checks++;
    if (lane_dout(3) !== 8'h06) begin
      failures++;
      $display("FAIL manual_dout got=%h exp=06", lane_dout(3));
    end
  endtask

  task automatic test_stream();
    logic [7:0] xh [NCH][48];
    for (int i = 0; i < 6; i++) begin
      slip = NCH'($urandom);
      for (int c = 0; c < NCH; c++)
        if (slip[c]) exp_s[c] = (exp_s[c] + 1) % W;
      @(negedge clk);
    end
    slip = '0;
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (lane_pos(c) !== exp_s[c]) begin
        failures++;
        $display("FAIL stream_slippos lane%0d got=%0d exp=%0d",
                 c, lane_pos(c), exp_s[c]);
      end
    end
    for (int k = 0; k < 48; k++) begin
      if (k >= 3)
        for (int c = 0; c < NCH; c++) begin
          checks++;
          if (lane_dout(c) !== win(xh[c][k-2], xh[c][k-3], exp_s[c])) begin
            failures++;
            $display("FAIL stream_dout lane%0d cyc%0d got=%h exp=%h",
                     c, k, lane_dout(c),
                     win(xh[c][k-2], xh[c][k-3], exp_s[c]));
          end
        end
      for (int c = 0; c < NCH; c++) begin
        lane_din[c] = 8'($urandom);
        lane_pol[c] = 1'($urandom);
        xh[c][k] = lane_pol[c] ? ~lane_din[c] : lane_din[c];
      end
      drive();
      @(negedge clk);
    end
  endtask

  task automatic test_align_basic();
    do_reset();
    lane_din[0] = 8'h1E; lane_pol[0] = 1'b0;
    lane_din[1] = 8'hF0; lane_pol[1] = 1'b1;
    lane_din[2] = 8'hAA; lane_pol[2] = 1'b0;
    lane_din[3] = 8'($urandom); lane_pol[3] = 1'($urandom);
    run_search("basic");
    checks++;
    if (lane_pos(0) !== 3 || lane_pos(1) !== 4 || lane_pos(2) !== 0) begin
      failures++;
      $display("FAIL basic_positions got=%0d,%0d,%0d exp=3,4,0",
               lane_pos(0), lane_pos(1), lane_pos(2));
    end
    slip[2] = 1'b1;
    @(negedge clk);
    slip[2] = 1'b0;
    exp_s[2] = (exp_s[2] + 1) % W;
    @(negedge clk);
    checks++;
    if (err[2] !== 1'b1 || lane_pos(2) !== exp_s[2]) begin
      failures++;
      $display("FAIL fail_slip got=%b/%0d exp=1/%0d",
               err[2], lane_pos(2), exp_s[2]);
    end
  endtask

  task automatic test_random_search();
    for (int it = 0; it < 3; it++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 3) != 0) set_lockable(c);
        else begin
          lane_din[c] = 8'($urandom);
          lane_pol[c] = 1'($urandom);
        end
      for (int i = 0; i < 8; i++) begin
        slip = NCH'($urandom);
        for (int c = 0; c < NCH; c++)
          if (slip[c]) exp_s[c] = (exp_s[c] + 1) % W;
        @(negedge clk);
      end
      slip = '0;
      run_search("rand");
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lane_din[0] = 8'h1E;
    lane_pol[0] = 1'b0;
    drive();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (lane_pos(0) !== 1) begin
      failures++;
      $display("FAIL midreset_pre got=%0d exp=1", lane_pos(0));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) exp_s[c] = 0;
    checks++;
    if (spos !== '0 || done !== '0 || dout !== '0) begin
      failures++;
      $display("FAIL midreset_clear got=%h/%b/%h exp=0",
               spos, done, dout);
    end
    run_search("relock");
  endtask

  task automatic test_all_aligned();
    for (int c = 0; c < NCH; c++) set_lockable(c);
    run_search("all");
    checks++;
    if (all_al !== 1'b1) begin
      failures++;
      $display("FAIL all_aligned got=%b exp=1", all_al);
    end
    lane_pol[1] = ~lane_pol[1];
    drive();
    repeat (4) @(negedge clk);
    checks++;
    if (done !== '1) begin
      failures++;
      $display("FAIL pol_change_done got=%b exp=1111", done);
    end
    slip[0] = 1'b1;
    @(negedge clk);
    slip[0] = 1'b0;
    exp_s[0] = (exp_s[0] + 1) % W;
    checks++;
    if (done[0] !== 1'b0 || all_al !== 1'b0) begin
      failures++;
      $display("FAIL unlock got=%b/%b exp=0/0", done[0], all_al);
    end
    checks++;
    if (lane_pos(0) !== exp_s[0]) begin
      failures++;
      $display("FAIL unlock_slippos got=%0d exp=%0d",
               lane_pos(0), exp_s[0]);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== '0 || err !== '0) begin
      failures++;
      $display("FAIL restart_clear got=%b/%b exp=0/0", done, err);
    end
  endtask

  initial begin
    test_reset();
    test_manual_slip();
    test_stream();
    test_align_basic();
    test_random_search();
    test_reset_mid();
    test_all_aligned();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
